// File: rtl/sensor_uart_tx_arbiter_if.sv
// Handshake bundle between the two sensor streams, the arbiter and the UART TX byte interface.
// master: sensor controllers + UART serializer side; slave: the arbiter itself.
interface sensor_uart_tx_arbiter_if #(
  parameter int ECG_BYTES   = 6,
  parameter int TOUCH_BYTES = 2
);
  logic                     i_ECG_VALID;
  logic [ECG_BYTES*8-1:0]   i_ECG_DATA;
  logic                     o_ECG_READY;
  logic                     i_TOUCH_VALID;
  logic [TOUCH_BYTES*8-1:0] i_TOUCH_DATA;
  logic                     o_TOUCH_READY;
  logic                     o_TX_VALID;
  logic [7:0]               o_TX_DATA;
  logic                     i_TX_READY;
  logic                     o_BUSY;
  logic [1:0]               o_GRANT;

  modport master (
    output i_ECG_VALID, i_ECG_DATA, i_TOUCH_VALID, i_TOUCH_DATA, i_TX_READY,
    input  o_ECG_READY, o_TOUCH_READY, o_TX_VALID, o_TX_DATA, o_BUSY, o_GRANT
  );

  modport slave (
    input  i_ECG_VALID, i_ECG_DATA, i_TOUCH_VALID, i_TOUCH_DATA, i_TX_READY,
    output o_ECG_READY, o_TOUCH_READY, o_TX_VALID, o_TX_DATA, o_BUSY, o_GRANT
  );
endinterface

// File: rtl/sensor_uart_tx_arbiter.sv
// Round-robin sharing of one UART TX byte stream between ECG and touch samples.
// Frame: HEADER, ID, LEN, payload (MSB first), checksum of ID+LEN+payload.
module sensor_uart_tx_arbiter #(
  parameter int         ECG_BYTES   = 6,
  parameter int         TOUCH_BYTES = 2,
  parameter logic [7:0] HEADER      = 8'hA5,
  parameter logic [7:0] ECG_ID      = 8'h01,
  parameter logic [7:0] TOUCH_ID    = 8'h02
) (
  input  logic                     i_CLK,
  input  logic                     i_RST,
  sensor_uart_tx_arbiter_if.slave  bus
);

  localparam int MAXB = (ECG_BYTES > TOUCH_BYTES) ? ECG_BYTES : TOUCH_BYTES;
  localparam int PW   = MAXB * 8;
  localparam int CW   = (MAXB > 1) ? $clog2(MAXB) : 1;

  typedef enum logic [2:0] {S_IDLE, S_HDR, S_ID, S_LEN, S_PAY, S_CHK} state_t;

  state_t          state_q, state_d;
  logic            tx_valid_q, tx_valid_d;
  logic [7:0]      tx_data_q, tx_data_d;
  logic [1:0]      grant_q, grant_d;
  logic            rr_q, rr_d;          // 1: touch has priority on a tie
  logic [PW-1:0]   payload_q, payload_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [7:0]      cks_q, cks_d;

  logic            ecg_ready, touch_ready, xfer;
  logic [CW-1:0]   first_idx;
  logic [7:0]      len_byte, id_byte, pay_byte, first_byte;

  // READY is gated by reset so neither source sees a handshake while held in reset.
  always_comb begin
    ecg_ready   = 1'b0;
    touch_ready = 1'b0;
    if (state_q == S_IDLE && !i_RST) begin
      ecg_ready   = bus.i_ECG_VALID   & (!bus.i_TOUCH_VALID | !rr_q);
      touch_ready = bus.i_TOUCH_VALID & (!bus.i_ECG_VALID   |  rr_q);
    end
  end

  assign xfer       = tx_valid_q & bus.i_TX_READY;
  assign len_byte   = grant_q[0] ? 8'(ECG_BYTES) : 8'(TOUCH_BYTES);
  assign id_byte    = grant_q[0] ? ECG_ID : TOUCH_ID;
  assign first_idx  = grant_q[0] ? CW'(ECG_BYTES - 1) : CW'(TOUCH_BYTES - 1);
  assign pay_byte   = payload_q[{cnt_q, 3'b000} +: 8];
  assign first_byte = payload_q[{first_idx, 3'b000} +: 8];

  always_comb begin
    state_d    = state_q;
    tx_valid_d = tx_valid_q;
    tx_data_d  = tx_data_q;
    grant_d    = grant_q;
    rr_d       = rr_q;
    payload_d  = payload_q;
    cnt_d      = cnt_q;
    cks_d      = cks_q;
    case (state_q)
      S_IDLE: begin
        if (ecg_ready || touch_ready) begin
          payload_d  = ecg_ready ? PW'(bus.i_ECG_DATA) : PW'(bus.i_TOUCH_DATA);
          grant_d    = {touch_ready, ecg_ready};
          cks_d      = 8'h00;
          tx_valid_d = 1'b1;
          tx_data_d  = HEADER;
          state_d    = S_HDR;
        end
      end
      S_HDR: if (xfer) begin
        tx_data_d = id_byte;
        state_d   = S_ID;
      end
      S_ID: if (xfer) begin
        cks_d     = cks_q + tx_data_q;
        tx_data_d = len_byte;
        state_d   = S_LEN;
      end
      S_LEN: if (xfer) begin
        cks_d     = cks_q + tx_data_q;
        cnt_d     = first_idx;
        tx_data_d = first_byte;
        state_d   = S_PAY;
      end
      S_PAY: if (xfer) begin
        cks_d = cks_q + tx_data_q;
        if (cnt_q == '0) begin
          // The checksum byte already includes the payload byte leaving now.
          tx_data_d = cks_q + tx_data_q;
          state_d   = S_CHK;
        end else begin
          cnt_d     = cnt_q - 1'b1;
          tx_data_d = payload_q[{cnt_q - 1'b1, 3'b000} +: 8];
        end
      end
      S_CHK: if (xfer) begin
        tx_valid_d = 1'b0;
        tx_data_d  = 8'h00;
        rr_d       = grant_q[0];
        state_d    = S_IDLE;
      end
      default: begin
        state_d    = S_IDLE;
        tx_valid_d = 1'b0;
        tx_data_d  = 8'h00;
      end
    endcase
  end

  always_ff @(posedge i_CLK or posedge i_RST) begin
    if (i_RST) begin
      state_q    <= S_IDLE;
      tx_valid_q <= 1'b0;
      tx_data_q  <= 8'h00;
      grant_q    <= 2'b00;
      rr_q       <= 1'b0;
      payload_q  <= '0;
      cnt_q      <= '0;
      cks_q      <= 8'h00;
    end else begin
      state_q    <= state_d;
      tx_valid_q <= tx_valid_d;
      tx_data_q  <= tx_data_d;
      grant_q    <= grant_d;
      rr_q       <= rr_d;
      payload_q  <= payload_d;
      cnt_q      <= cnt_d;
      cks_q      <= cks_d;
    end
  end

  assign bus.o_ECG_READY   = ecg_ready;
  assign bus.o_TOUCH_READY = touch_ready;
  assign bus.o_TX_VALID    = tx_valid_q;
  assign bus.o_TX_DATA     = tx_data_q;
  assign bus.o_BUSY        = (state_q != S_IDLE);
  assign bus.o_GRANT       = grant_q;

endmodule

// File: tb/tb_sensor_uart_tx_arbiter.sv
// Directed bench for sensor_uart_tx_arbiter: framing, round-robin, backpressure, mid-frame reset.
module tb_sensor_uart_tx_arbiter;

  typedef logic [7:0] byte_q_t[$];

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_pass   = 0;

  always #5 clk = ~clk;

  sensor_uart_tx_arbiter_if #(.ECG_BYTES(6), .TOUCH_BYTES(2)) bus_if ();

  sensor_uart_tx_arbiter #(
    .ECG_BYTES(6), .TOUCH_BYTES(2), .HEADER(8'hA5), .ECG_ID(8'h01), .TOUCH_ID(8'h02)
  ) dut (
    .i_CLK(clk),
    .i_RST(rst),
    .bus  (bus_if.slave)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Checks one frame byte per cycle; optionally drops valids after the first byte
  // and stalls i_TX_READY for 5 cycles on byte index stall_at.
  task automatic frame(input string tag, input byte_q_t q, input bit drop_e,
                       input bit drop_t, input int stall_at);
    for (int i = 0; i < q.size(); i++) begin
      @(negedge clk);
      chk($sformatf("%s valid%0d", tag, i), bus_if.o_TX_VALID, 1);
      chk($sformatf("%s byte%0d", tag, i), bus_if.o_TX_DATA, q[i]);
      chk($sformatf("%s ready_low%0d", tag, i), {bus_if.o_ECG_READY, bus_if.o_TOUCH_READY}, 0);
      if (i == 0) begin
        if (drop_e) bus_if.i_ECG_VALID = 1'b0;
        if (drop_t) bus_if.i_TOUCH_VALID = 1'b0;
      end
      if (i == stall_at) begin
        bus_if.i_TX_READY = 1'b0;
        for (int s = 0; s < 5; s++) begin
          @(negedge clk);
          chk($sformatf("%s stall_valid%0d", tag, s), bus_if.o_TX_VALID, 1);
          chk($sformatf("%s stall_byte%0d", tag, s), bus_if.o_TX_DATA, q[i]);
        end
        bus_if.i_TX_READY = 1'b1;
      end
    end
  endtask

  initial begin
    byte_q_t q_ecg, q_touch, q_touch_part;
    q_ecg        = '{8'hA5, 8'h01, 8'h06, 8'h12, 8'h34, 8'h56, 8'hAB, 8'hCD, 8'hEF, 8'h0A};
    q_touch      = '{8'hA5, 8'h02, 8'h02, 8'h0F, 8'hF0, 8'h03};
    q_touch_part = '{8'hA5, 8'h02, 8'h02, 8'h0F};

    bus_if.i_ECG_VALID   = 1'b1;
    bus_if.i_ECG_DATA    = 48'h123456ABCDEF;
    bus_if.i_TOUCH_VALID = 1'b1;
    bus_if.i_TOUCH_DATA  = 16'h0FF0;
    bus_if.i_TX_READY    = 1'b1;

    // Reset state, with both sources valid to show READY stays low in reset.
    repeat (2) @(negedge clk);
    chk("rst tx_valid", bus_if.o_TX_VALID, 0);
    chk("rst tx_data", bus_if.o_TX_DATA, 8'h00);
    chk("rst busy", bus_if.o_BUSY, 0);
    chk("rst grant", bus_if.o_GRANT, 2'b00);
    chk("rst readies", {bus_if.o_ECG_READY, bus_if.o_TOUCH_READY}, 2'b00);

    // ECG only.
    rst = 1'b0;
    bus_if.i_TOUCH_VALID = 1'b0;
    #1 chk("ecg1 ready", {bus_if.o_ECG_READY, bus_if.o_TOUCH_READY}, 2'b10);
    frame("ecg1", q_ecg, 1, 1, -1);
    @(negedge clk);
    chk("ecg1 idle valid", bus_if.o_TX_VALID, 0);
    chk("ecg1 idle busy", bus_if.o_BUSY, 0);
    chk("ecg1 grant", bus_if.o_GRANT, 2'b01);

    // Touch only.
    bus_if.i_TOUCH_VALID = 1'b1;
    #1 chk("touch1 ready", {bus_if.o_ECG_READY, bus_if.o_TOUCH_READY}, 2'b01);
    frame("touch1", q_touch, 1, 1, -1);
    @(negedge clk);
    chk("touch1 idle valid", bus_if.o_TX_VALID, 0);
    chk("touch1 grant", bus_if.o_GRANT, 2'b10);

    // Both held: ECG (last was touch), touch, ECG.
    bus_if.i_ECG_VALID   = 1'b1;
    bus_if.i_TOUCH_VALID = 1'b1;
    #1 chk("rr1 ready", {bus_if.o_ECG_READY, bus_if.o_TOUCH_READY}, 2'b10);
    frame("rr_ecg_a", q_ecg, 0, 0, -1);
    @(negedge clk);
    chk("rr2 idle valid", bus_if.o_TX_VALID, 0);
    #1 chk("rr2 ready", {bus_if.o_ECG_READY, bus_if.o_TOUCH_READY}, 2'b01);
    frame("rr_touch", q_touch, 0, 0, -1);
    @(negedge clk);
    chk("rr3 idle valid", bus_if.o_TX_VALID, 0);
    #1 chk("rr3 ready", {bus_if.o_ECG_READY, bus_if.o_TOUCH_READY}, 2'b10);
    frame("rr_ecg_b", q_ecg, 1, 1, -1);
    @(negedge clk);
    chk("rr4 idle valid", bus_if.o_TX_VALID, 0);

    // Backpressure on the third payload byte.
    bus_if.i_ECG_VALID = 1'b1;
    #1 chk("bp ready", {bus_if.o_ECG_READY, bus_if.o_TOUCH_READY}, 2'b10);
    frame("bp", q_ecg, 1, 1, 5);
    @(negedge clk);
    chk("bp idle valid", bus_if.o_TX_VALID, 0);
    chk("bp idle busy", bus_if.o_BUSY, 0);

    // Reset during touch payload.
    bus_if.i_TOUCH_VALID = 1'b1;
    #1 chk("mr ready", {bus_if.o_ECG_READY, bus_if.o_TOUCH_READY}, 2'b01);
    frame("mr_part", q_touch_part, 1, 1, -1);
    bus_if.i_ECG_VALID   = 1'b1;
    bus_if.i_TOUCH_VALID = 1'b1;
    #1 rst = 1'b1;
    #1;
    chk("mr tx_valid", bus_if.o_TX_VALID, 0);
    chk("mr busy", bus_if.o_BUSY, 0);
    chk("mr grant", bus_if.o_GRANT, 2'b00);
    chk("mr tx_data", bus_if.o_TX_DATA, 8'h00);
    chk("mr readies", {bus_if.o_ECG_READY, bus_if.o_TOUCH_READY}, 2'b00);
    @(negedge clk);
    rst = 1'b0;
    #1 chk("mr rr reset", {bus_if.o_ECG_READY, bus_if.o_TOUCH_READY}, 2'b10);
    frame("mr_ecg", q_ecg, 1, 0, -1);
    @(negedge clk);
    chk("mr idle valid", bus_if.o_TX_VALID, 0);
    #1 chk("mr touch ready", {bus_if.o_ECG_READY, bus_if.o_TOUCH_READY}, 2'b01);
    frame("mr_touch", q_touch, 0, 1, -1);
    @(negedge clk);
    chk("end idle valid", bus_if.o_TX_VALID, 0);
    chk("end busy", bus_if.o_BUSY, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
